alarm_bank: RTL and testbench

Parametrised multi-channel alarm engine for the digital-clock system, successor to the single-alarm compare-and-beep path. It holds N_ALARM programmable BCD HH:MM alarm times with per-channel enable. Each channel has its own ring/snooze state machine with ring timeout. The block drives a cadenced tone to the buzzer. It sits beside the time counter (time digits plus second and minute ticks) and key_scan/cpu, which supply writes, ack and snooze.

---
 rtl/alarm_bank.sv | 175 +++++++++++++++++
 tb/tb_alarm_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_bank.sv
// Multi-channel BCD HH:MM alarm engine: per-channel ring/snooze FSMs plus cadenced buzzer tone.
// Latency: ring_vec changes 1 cycle after the causing pulse; wr_err pulses the cycle after wr_en.
// Backpressure: none; all control inputs are single-cycle pulses consumed in the cycle they arrive.
module alarm_bank #(
    parameter int N_ALARM    = 4,
    parameter int IDX_W      = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int TONE_DIV   = 25000
) (
    input  logic               mclk,
    input  logic               rst_n,
    input  logic               sec_tick,
    input  logic               min_tick,
    input  logic [2:0]         hour_ten,
    input  logic [3:0]         hour_one,
    input  logic [2:0]         minute_ten,
    input  logic [3:0]         minute_one,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [13:0]        wr_time,
    input  logic               wr_on,
    input  logic               ack,
    input  logic               snooze,
    output logic [N_ALARM-1:0] ring_vec,
    output logic               ring_any,
    output logic [IDX_W-1:0]   ring_idx,
    output logic               wr_err,
    output logic               beep
);

    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOZ} state_t;

    localparam logic [7:0]  RING_LAST = 8'(RING_SEC);
    localparam logic [5:0]  SNZ_LOAD  = 6'(SNOOZE_MIN);
    localparam logic [15:0] TONE_LAST = 16'(TONE_DIV - 1);

    state_t       state_q    [N_ALARM];
    logic [7:0]   ring_cnt_q [N_ALARM];
    logic [5:0]   snz_cnt_q  [N_ALARM];
    logic [13:0]  tim_q      [N_ALARM];
    logic         en_q       [N_ALARM];

    logic [15:0]  div_q;
    logic         tone_q;
    logic         cad_q;
    logic         wr_err_q;

    logic [13:0]  cur_time;
    logic         wr_bad;
    logic         wr_ok;
    logic [N_ALARM-1:0] match;

    assign cur_time = {hour_ten, hour_one, minute_ten, minute_one};

    // Reject out-of-range channel or any non-BCD / out-of-range time field.
    always_comb begin
        wr_bad = 1'b0;
        if (32'(wr_idx) >= 32'(N_ALARM))                          wr_bad = 1'b1;
        if (wr_time[10:7] > 4'd9 || wr_time[3:0] > 4'd9)           wr_bad = 1'b1;
        if (wr_time[6:4] > 3'd5)                                   wr_bad = 1'b1;
        if (wr_time[13:11] > 3'd2)                                 wr_bad = 1'b1;
        if (wr_time[13:11] == 3'd2 && wr_time[10:7] > 4'd3)        wr_bad = 1'b1;
        wr_ok = wr_en && !wr_bad;
    end

    // Per-channel compare of stored alarm time against the running clock, and ring state decode.
    always_comb begin
        match    = '0;
        ring_vec = '0;
        for (int i = 0; i < N_ALARM; i++) begin
            match[i]    = en_q[i] && (tim_q[i] == cur_time);
            ring_vec[i] = (state_q[i] == ST_RING);
        end
    end

    // Lowest ringing channel wins; 0 when nothing rings.
    always_comb begin
        ring_idx = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (ring_vec[i]) ring_idx = IDX_W'(i);
        end
    end

    assign ring_any = |ring_vec;
    assign wr_err   = wr_err_q;
    // Gating with ring_any makes beep drop in the same cycle the last channel stops.
    assign beep     = tone_q && cad_q && ring_any;

    // Storage and ring/snooze FSM per channel; an accepted write outranks every event.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ALARM; i++) begin
                state_q[i]    <= ST_IDLE;
                ring_cnt_q[i] <= '0;
                snz_cnt_q[i]  <= '0;
                tim_q[i]      <= '0;
                en_q[i]       <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_ALARM; i++) begin
                if (wr_ok && wr_idx == IDX_W'(i)) begin
                    tim_q[i]      <= wr_time;
                    en_q[i]       <= wr_on;
                    state_q[i]    <= ST_IDLE;
                    ring_cnt_q[i] <= '0;
                    snz_cnt_q[i]  <= '0;
                end else begin
                    case (state_q[i])
                        ST_IDLE: begin
                            if (min_tick && match[i]) begin
                                state_q[i]    <= ST_RING;
                                ring_cnt_q[i] <= '0;
                            end
                        end
                        ST_RING: begin
                            if (ack) begin
                                state_q[i] <= ST_IDLE;
                            end else if (snooze) begin
                                state_q[i]   <= ST_SNOZ;
                                snz_cnt_q[i] <= SNZ_LOAD;
                            end else if (sec_tick) begin
                                ring_cnt_q[i] <= ring_cnt_q[i] + 8'd1;
                                if (ring_cnt_q[i] + 8'd1 == RING_LAST) state_q[i] <= ST_IDLE;
                            end
                        end
                        ST_SNOZ: begin
                            if (ack) begin
                                state_q[i] <= ST_IDLE;
                            end else if (min_tick) begin
                                // A fresh time match overrides the remaining snooze interval.
                                if (match[i] || snz_cnt_q[i] == 6'd1) begin
                                    state_q[i]    <= ST_RING;
                                    ring_cnt_q[i] <= '0;
                                    snz_cnt_q[i]  <= '0;
                                end else begin
                                    snz_cnt_q[i] <= snz_cnt_q[i] - 6'd1;
                                end
                            end
                        end
                        default: state_q[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Tone divider and 1 s cadence run only while something rings, otherwise held at 0/0/1.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tone_q <= 1'b0;
            cad_q  <= 1'b1;
        end else if (!ring_any) begin
            div_q  <= '0;
            tone_q <= 1'b0;
            cad_q  <= 1'b1;
        end else begin
            if (div_q == TONE_LAST) begin
                div_q  <= '0;
                tone_q <= ~tone_q;
            end else begin
                div_q <= div_q + 16'd1;
            end
            if (sec_tick) cad_q <= ~cad_q;
        end
    end

    // Rejected-write flag, visible for exactly the cycle after the strobe.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) wr_err_q <= 1'b0;
        else        wr_err_q <= wr_en && wr_bad;
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank with short ring timeout and tone divider.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// No flow control; every wait is a fixed number of cycles.
module tb_alarm_bank;

    localparam int N_ALARM = 4;
    localparam int IDX_W   = 2;

    logic               mclk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sec_tick = 1'b0;
    logic               min_tick = 1'b0;
    logic [2:0]         hour_ten = '0;
    logic [3:0]         hour_one = '0;
    logic [2:0]         minute_ten = '0;
    logic [3:0]         minute_one = '0;
    logic               wr_en = 1'b0;
    logic [IDX_W-1:0]   wr_idx = '0;
    logic [13:0]        wr_time = '0;
    logic               wr_on = 1'b0;
    logic               ack = 1'b0;
    logic               snooze = 1'b0;
    logic [N_ALARM-1:0] ring_vec;
    logic               ring_any;
    logic [IDX_W-1:0]   ring_idx;
    logic               wr_err;
    logic               beep;

    int checks   = 0;
    int failures = 0;

    alarm_bank #(
        .N_ALARM   (N_ALARM),
        .IDX_W     (IDX_W),
        .SNOOZE_MIN(5),
        .RING_SEC  (3),
        .TONE_DIV  (4)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .sec_tick  (sec_tick),
        .min_tick  (min_tick),
        .hour_ten  (hour_ten),
        .hour_one  (hour_one),
        .minute_ten(minute_ten),
        .minute_one(minute_one),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_time   (wr_time),
        .wr_on     (wr_on),
        .ack       (ack),
        .snooze    (snooze),
        .ring_vec  (ring_vec),
        .ring_any  (ring_any),
        .ring_idx  (ring_idx),
        .wr_err    (wr_err),
        .beep      (beep)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ring(input string tag, input logic [3:0] exp_vec, input logic [1:0] exp_idx);
        chk({tag, ".vec"}, 32'(ring_vec), 32'(exp_vec));
        chk({tag, ".any"}, 32'(ring_any), 32'(|exp_vec));
        chk({tag, ".idx"}, 32'(ring_idx), 32'(exp_idx));
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic set_time(input int h10, input int h1, input int m10, input int m1);
        hour_ten   = 3'(h10);
        hour_one   = 4'(h1);
        minute_ten = 3'(m10);
        minute_one = 4'(m1);
    endtask

    function automatic logic [13:0] mk(input int h10, input int h1, input int m10, input int m1);
        return {3'(h10), 4'(h1), 3'(m10), 4'(m1)};
    endfunction

    task automatic pulse_min();
        min_tick = 1'b1;
        step();
        min_tick = 1'b0;
    endtask

    task automatic pulse_sec();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic write(input int idx, input logic [13:0] t, input logic on);
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(idx);
        wr_time = t;
        wr_on   = on;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        logic cad_e;
        logic tone_e;

        // Reset state
        step();
        step();
        chk_ring("reset", 4'b0000, 2'd0);
        chk("reset.wr_err", 32'(wr_err), 32'd0);
        chk("reset.beep", 32'(beep), 32'd0);
        rst_n = 1'b1;
        step();

        // Channel 1 at 07:30 triggers on the matching minute tick
        write(1, mk(0, 7, 3, 0), 1'b1);
        chk("wr_ok.err", 32'(wr_err), 32'd0);
        set_time(0, 7, 3, 0);
        step();
        chk_ring("no_tick", 4'b0000, 2'd0);
        pulse_min();
        chk_ring("trig_ch1", 4'b0010, 2'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_ring("ack_ch1", 4'b0000, 2'd0);

        // Invalid writes pulse wr_err for one cycle and leave channel 0 at 00:00 off
        write(0, mk(2, 4, 0, 0), 1'b1);
        chk("bad_hour.err", 32'(wr_err), 32'd1);
        step();
        chk("bad_hour.err_clr", 32'(wr_err), 32'd0);
        write(0, mk(0, 0, 0, 10), 1'b1);
        chk("bad_m1.err", 32'(wr_err), 32'd1);
        step();
        chk("bad_m1.err_clr", 32'(wr_err), 32'd0);
        write(0, mk(0, 0, 6, 0), 1'b1);
        chk("bad_m10.err", 32'(wr_err), 32'd1);
        set_time(0, 0, 0, 0);
        pulse_min();
        chk_ring("no_ring_0000", 4'b0000, 2'd0);

        // 23:59 is the last legal time and rings channel 3
        write(3, mk(2, 3, 5, 9), 1'b1);
        chk("wr_2359.err", 32'(wr_err), 32'd0);
        set_time(2, 3, 5, 9);
        pulse_min();
        chk_ring("trig_ch3", 4'b1000, 2'd3);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_ring("ack_ch3", 4'b0000, 2'd0);

        // Channels 0 and 2 at 06:00; snooze both, re-ring after the 5th minute tick
        write(0, mk(0, 6, 0, 0), 1'b1);
        write(2, mk(0, 6, 0, 0), 1'b1);
        set_time(0, 6, 0, 0);
        pulse_min();
        chk_ring("trig_ch02", 4'b0101, 2'd0);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk_ring("snooze", 4'b0000, 2'd0);
        for (int m = 1; m <= 4; m++) begin
            set_time(0, 6, 0, m);
            pulse_min();
            chk_ring("snz_wait", 4'b0000, 2'd0);
        end
        set_time(0, 6, 0, 5);
        pulse_min();
        chk_ring("re_ring", 4'b0101, 2'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_ring("ack_re_ring", 4'b0000, 2'd0);

        // Timeout after 3 second ticks
        set_time(0, 6, 0, 0);
        pulse_min();
        chk_ring("trig_to", 4'b0101, 2'd0);
        pulse_sec();
        step();
        pulse_sec();
        chk_ring("to_2ticks", 4'b0101, 2'd0);
        step();
        pulse_sec();
        chk_ring("timeout", 4'b0000, 2'd0);
        chk("timeout.beep", 32'(beep), 32'd0);

        // ack together with snooze stops for good
        set_time(0, 6, 0, 0);
        pulse_min();
        chk_ring("trig_as", 4'b0101, 2'd0);
        ack    = 1'b1;
        snooze = 1'b1;
        step();
        ack    = 1'b0;
        snooze = 1'b0;
        chk_ring("ack_snooze", 4'b0000, 2'd0);
        for (int m = 1; m <= 6; m++) begin
            set_time(0, 6, 0, m);
            pulse_min();
            chk_ring("no_re_ring", 4'b0000, 2'd0);
        end

        // Tone: half-period 4 cycles, gated by the per-second cadence
        set_time(0, 7, 3, 0);
        pulse_min();
        chk_ring("trig_tone", 4'b0010, 2'd1);
        chk("tone.k0", 32'(beep), 32'd0);
        cad_e = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            sec_tick = (k == 12 || k == 20);
            step();
            sec_tick = 1'b0;
            if (k == 12 || k == 20) cad_e = ~cad_e;
            tone_e = ((k / 4) % 2) == 1;
            chk("tone.beep", 32'(beep), 32'(tone_e && cad_e));
        end
        chk_ring("tone_still", 4'b0010, 2'd1);

        // Asynchronous reset mid-ring clears outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk_ring("arst", 4'b0000, 2'd0);
        chk("arst.beep", 32'(beep), 32'd0);
        chk("arst.wr_err", 32'(wr_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        pulse_min();
        chk_ring("post_rst", 4'b0000, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
